mfi_issue_ctrl: RTL
===================

// Module: mfi_issue_ctrl
// PURPOSE
//   Issue sequencer between an instruction source and the core's inst/inst_valid input.
//   Buffers requested instructions in a FIFO and issues at most one per cycle.
//   Limits in-flight instructions and tracks retirement on the MFI retire port
//     (mfi_valid/mfi_order/mfi_trap).
//   Halts issue on trap, retire-order error or retire timeout.
// PARAMETERS
//   DEPTH         4   FIFO entries; power of 2, >= 2
//   MAX_INFLIGHT  2   max issued-but-unretired instructions, >= 1
//   TIMEOUT       15  cycles with inflight>0 and no retire before timeout_err, >= 1
// PORTS
//   clock          in   1   single clock, all state on posedge
//   reset          in   1   synchronous, active-high
//   req_valid      in   1   requester offers req_inst
//   req_inst       in   32  instruction word
//   req_ready      out  1   FIFO accepts; transfer when req_valid & req_ready
//   flush          in   1   discard FIFO contents; in HALT also returns to RUN
//   inst_valid     out  1   registered; one-cycle pulse per issued instruction
//   inst           out  32  registered; instruction word, valid with inst_valid
//   mfi_valid      in   1   core retires an instruction this cycle
//   mfi_order      in   32  retire sequence number
//   mfi_trap       in   1   retired instruction trapped (qualified by mfi_valid)
//   inflight       out  $clog2(MAX_INFLIGHT+1)  issued minus retired
//   issued_count   out  32  total issues since reset, wraps 2^32-1 -> 0
//   retired_count  out  32  total valid retires since reset, wraps
//   order_err      out  1   sticky until reset
//   timeout_err    out  1   sticky until reset
//   state          out  2   RUN=0, DRAIN=1, HALT=2
// BEHAVIOUR
//   Reset values
//     All outputs 0; state=RUN; FIFO empty; expected order=0; timeout counter=0.
//     Reset overrides everything, including mid-operation; in-flight tracking is discarded.
//   req_ready = !full & state!=HALT & !flush (combinational).
//     Push and pop in the same cycle are legal; a full FIFO does not bypass.
//   Issue condition (cycle N): state==RUN & FIFO non-empty & !flush
//     & (inflight < MAX_INFLIGHT | mfi_valid).
//     Pop the head; inst/inst_valid are visible at N+1.
//     Latency: accepted into an empty FIFO at cycle N -> inst_valid at N+2.
//   inflight: +1 on issue, -1 on mfi_valid; both in one cycle -> unchanged.
//     mfi_valid with inflight==0 (no same-cycle issue): order_err=1, inflight stays 0.
//   Order check: on mfi_valid, mfi_order != expected -> order_err=1.
//     expected increments on every mfi_valid regardless of match (32-bit wrap).
//   Timeout counter
//     Clears on mfi_valid or when inflight==0; otherwise +1 per cycle.
//     At count == TIMEOUT: timeout_err=1 and state->HALT.
//   FSM
//     RUN   -> DRAIN  on mfi_valid&mfi_trap, or order_err rising (same cycle as detection).
//     DRAIN : no issue. -> HALT when inflight reaches 0 (counting same-cycle retire).
//     HALT  : no issue, req_ready=0, FIFO cleared on entry.
//             -> RUN on flush; errors remain set.
//     Timeout in DRAIN -> HALT.
//   flush: FIFO emptied at the edge; an issue already registered still outputs;
//     in-flight instructions keep being tracked.
//   Counters wrap silently; retires in DRAIN/HALT are still counted and order-checked.
// TESTING
//   1. Push 0x00000013, 0x00100093, 0x00200113 back-to-back; retire each 1 cycle after
//      issue with orders 0,1,2 -> three inst_valid pulses in order; issued=retired=3;
//      no errors; state=RUN.
//   2. Push 6, never retire (DEPTH=4, MAX_INFLIGHT=2) -> exactly 2 issues; req_ready low
//      once 4 are buffered; 15 cycles after the 2nd issue, timeout_err=1, state=HALT,
//      FIFO empty.
//   3. Retire orders 0 then 2 -> order_err=1 the cycle after the 2nd retire; state DRAIN,
//      then HALT when inflight=0; flush -> RUN with order_err still 1.
//   4. Trap on order 0 retire with one more in flight -> DRAIN, no inst_valid;
//      retire order 1 -> HALT.
//   5. inflight=2, FIFO non-empty, mfi_valid in the same cycle -> issue occurs that cycle;
//      inflight stays 2.
//   6. Reset mid-run (FIFO 3 entries, inflight 2) -> next cycle all outputs 0, state RUN;
//      first retire must carry order 0.

Source files
------------

// File: rtl/mfi_issue_ctrl.sv
// Issue sequencer: buffers requested instructions, issues at most one per cycle
// within an in-flight budget, and halts on trap, retire-order error or retire timeout.
module mfi_issue_ctrl #(
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 2,
  parameter int TIMEOUT      = 15
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                req_valid,
  input  logic [31:0]                         req_inst,
  output logic                                req_ready,
  input  logic                                flush,
  output logic                                inst_valid,
  output logic [31:0]                         inst,
  input  logic                                mfi_valid,
  input  logic [31:0]                         mfi_order,
  input  logic                                mfi_trap,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight,
  output logic [31:0]                         issued_count,
  output logic [31:0]                         retired_count,
  output logic                                order_err,
  output logic                                timeout_err,
  output logic [1:0]                          state
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] MAX_IF   = IW'(MAX_INFLIGHT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t          st;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [31:0]     exp_order;
  logic [TW-1:0]   tmo_cnt;

  logic            full;
  logic            empty;
  logic            push;
  logic            issue;
  logic            retire_ok;
  logic            orphan;
  logic            order_bad;
  logic            err_now;
  logic            order_rise;
  logic            tmo_hit;
  logic            go_drain;
  logic            go_halt;
  logic [IW-1:0]   inflight_next;

  assign state = st;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign req_ready = !full && (st != HALT) && !flush;
  assign push      = req_valid && req_ready;
  // A same-cycle retire frees a slot, so issue is allowed even at the in-flight limit.
  assign issue     = (st == RUN) && !empty && !flush && ((inflight < MAX_IF) || mfi_valid);

  assign retire_ok     = mfi_valid && ((inflight != '0) || issue);
  assign orphan        = mfi_valid && (inflight == '0) && !issue;
  assign order_bad     = mfi_valid && (mfi_order != exp_order);
  assign err_now       = orphan || order_bad;
  assign order_rise    = err_now && !order_err;
  assign inflight_next = inflight + IW'(issue) - IW'(retire_ok);

  // The timeout fires once, on the cycle the stall counter reaches TIMEOUT; it then saturates.
  assign tmo_hit  = !mfi_valid && (inflight != '0) && (tmo_cnt == TMO_LAST);
  assign go_drain = (st == RUN) && !tmo_hit && ((mfi_valid && mfi_trap) || order_rise);
  assign go_halt  = ((st == RUN) && tmo_hit) ||
                    ((st == DRAIN) && (tmo_hit || (inflight_next == '0)));

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= req_inst;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st            <= RUN;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      inst_valid    <= 1'b0;
      inst          <= '0;
      inflight      <= '0;
      issued_count  <= '0;
      retired_count <= '0;
      exp_order     <= '0;
      order_err     <= 1'b0;
      timeout_err   <= 1'b0;
      tmo_cnt       <= '0;
    end else begin
      case (st)
        RUN:     if (tmo_hit) st <= HALT; else if (go_drain) st <= DRAIN;
        DRAIN:   if (go_halt) st <= HALT;
        HALT:    if (flush) st <= RUN;
        default: st <= RUN;
      endcase

      if (flush || go_halt) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)  wr_ptr <= wr_ptr + 1'b1;
        if (issue) rd_ptr <= rd_ptr + 1'b1;
        count <= count + (AW+1)'(push) - (AW+1)'(issue);
      end

      inst_valid <= issue;
      if (issue) inst <= mem[rd_ptr];

      inflight      <= inflight_next;
      issued_count  <= issued_count + 32'(issue);
      retired_count <= retired_count + 32'(mfi_valid);
      exp_order     <= exp_order + 32'(mfi_valid);
      order_err     <= order_err | err_now;
      timeout_err   <= timeout_err | tmo_hit;

      if (mfi_valid || (inflight == '0)) tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX)       tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

endmodule
